// File: rtl/lzw_job_seq.sv
// Job sequencer around an LZW engine. It initialises the code RAM, loads a host job into the IO RAM,
// starts compression, and streams the engine's output RAM back to the host.
module lzw_job_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_host_vld,
  input  logic [7:0]  i_host_data,
  input  logic        i_host_last,
  output logic        o_host_rdy,
  output logic        o_out_vld,
  output logic [7:0]  o_out_data,
  output logic        o_out_last,
  input  logic        i_out_rdy,
  output logic        o_init_cr,
  output logic        o_init_lzw,
  input  logic        i_done_cr,
  input  logic        i_lzw_done,
  input  logic [11:0] i_outram_cnt,
  output logic [11:0] o_char_cnt,
  output logic        o_ioram_en,
  output logic        o_ioram_we,
  output logic [11:0] o_ioram_addr,
  output logic [7:0]  o_ioram_din,
  output logic        o_outram_en,
  output logic [11:0] o_outram_addr,
  input  logic [7:0]  i_outram_dout,
  output logic        o_busy,
  output logic        o_err_short,
  output logic        o_err_ovf,
  output logic        o_err_tmo
);

  // state  | meaning
  // CR_GO  | pulse init_cr for one cycle
  // CR_WT  | wait for done_cr (watchdog running)
  // LOAD   | accept host bytes into the IO RAM
  // RUN_GO | pulse init_lzw for one cycle
  // RUN_WT | wait for lzw_done (watchdog running)
  // UL_RD  | issue an output RAM read at rcnt
  // UL_OUT | present the byte until the host takes it
  localparam logic [2:0] S_CR_GO  = 3'd0;
  localparam logic [2:0] S_CR_WT  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN_GO = 3'd3;
  localparam logic [2:0] S_RUN_WT = 3'd4;
  localparam logic [2:0] S_UL_RD  = 3'd5;
  localparam logic [2:0] S_UL_OUT = 3'd6;

  logic [2:0]  r_state;
  logic [11:0] r_wcnt;
  logic [11:0] r_rcnt;
  logic [11:0] r_ulen;
  logic [11:0] r_char_cnt;
  logic [15:0] r_wd;
  logic [7:0]  r_hold;
  logic        r_first;
  logic        r_err_short;
  logic        r_err_ovf;
  logic        r_err_tmo;

  logic w_acc;
  logic w_ul_last;
  logic w_wd_exp;

  assign w_acc     = (r_state == S_LOAD) && i_host_vld;
  assign w_ul_last = (r_rcnt == (r_ulen - 12'd1));
  assign w_wd_exp  = (r_wd == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_CR_GO;
      r_wcnt      <= 12'd0;
      r_rcnt      <= 12'd0;
      r_ulen      <= 12'd0;
      r_char_cnt  <= 12'd0;
      r_wd        <= 16'd0;
      r_hold      <= 8'd0;
      r_first     <= 1'b0;
      r_err_short <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_CR_GO: begin
          r_wd    <= 16'd0;
          r_state <= S_CR_WT;
        end
        S_CR_WT: begin
          if (i_done_cr) begin
            r_state <= S_LOAD;
          end else if (w_wd_exp) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_CR_GO;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            // A one-byte job is discarded; wcnt is already zero so nothing to clear.
            if (i_host_last && (r_wcnt == 12'd0)) begin
              r_err_short <= 1'b1;
            end else if (i_host_last || (r_wcnt == 12'hFFF)) begin
              r_char_cnt <= r_wcnt;
              r_wcnt     <= 12'd0;
              if (!i_host_last) r_err_ovf <= 1'b1;
              r_state    <= S_RUN_GO;
            end else begin
              r_wcnt <= r_wcnt + 12'd1;
            end
          end
        end
        S_RUN_GO: begin
          r_wd    <= 16'd0;
          r_state <= S_RUN_WT;
        end
        S_RUN_WT: begin
          if (i_lzw_done) begin
            r_ulen  <= i_outram_cnt;
            r_rcnt  <= 12'd0;
            r_state <= (i_outram_cnt == 12'd0) ? S_CR_GO : S_UL_RD;
          end else if (w_wd_exp) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_CR_GO;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_UL_RD: begin
          r_first <= 1'b1;
          r_state <= S_UL_OUT;
        end
        S_UL_OUT: begin
          r_first <= 1'b0;
          if (r_first) r_hold <= i_outram_dout;
          if (i_out_rdy) begin
            r_rcnt  <= r_rcnt + 12'd1;
            r_state <= w_ul_last ? S_CR_GO : S_UL_RD;
          end
        end
        default: r_state <= S_CR_GO;
      endcase
    end
  end

  // rst_n gates init_cr so the pulse appears only in the first cycle after release.
  assign o_init_cr  = rst_n && (r_state == S_CR_GO);
  assign o_init_lzw = (r_state == S_RUN_GO);
  assign o_host_rdy = (r_state == S_LOAD);
  assign o_busy     = (r_state != S_LOAD);

  assign o_ioram_en   = w_acc;
  assign o_ioram_we   = w_acc;
  assign o_ioram_addr = r_wcnt;
  assign o_ioram_din  = i_host_data;
  assign o_char_cnt   = r_char_cnt;

  assign o_outram_en   = (r_state == S_UL_RD);
  assign o_outram_addr = r_rcnt;

  // Offering RAM data directly in the first UL_OUT cycle keeps the 2-cycle-per-byte rate.
  assign o_out_vld  = (r_state == S_UL_OUT);
  assign o_out_data = r_first ? i_outram_dout : r_hold;
  assign o_out_last = (r_state == S_UL_OUT) && w_ul_last;

  assign o_err_short = r_err_short;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_tmo   = r_err_tmo;

endmodule

// File: doc/lzw_job_seq.md
LZW_JOB_SEQ -- requirements
Module: lzw_job_seq

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  reset; synchronous, active-low.
REQ-003 host_vld / host_data / host_last  in  1/8/1  host byte-load stream; host_last marks the final byte of a job.
REQ-004 host_rdy  out  1  load-stream ready; a byte is accepted when host_vld & host_rdy.
REQ-005 out_vld / out_data / out_last  out  1/8/1  compressed-byte unload stream.
REQ-006 out_rdy  in  1  unload-stream ready.
REQ-007 init_cr / init_lzw  out  1/1  single-cycle start pulses to the LZW engine: code-RAM init and compression.
REQ-008 done_cr / lzw_done  in  1/1  engine completion pulses.
REQ-009 outram_cnt  in  12  engine output byte count.
REQ-010 char_cnt  out  12  index of the last loaded character, to the engine.
REQ-011 ioram_en / ioram_we / ioram_addr / ioram_din  out  1/1/12/8  IO RAM write port.
REQ-012 outram_en / outram_addr  out  1/12  output RAM read port.
REQ-013 outram_dout  in  8  output RAM read data, valid 1 cycle after outram_en.
REQ-014 busy  out  1  high in every state except LOAD.
REQ-015 err_short / err_ovf / err_tmo  out  1/1/1  sticky error flags; cleared only by reset.

Function
REQ-016 States: CR_GO, CR_WT, LOAD, RUN_GO, RUN_WT, UL_RD, UL_OUT.
REQ-017 CR_GO: assert init_cr for exactly 1 cycle, then go to CR_WT.
REQ-018 CR_WT: on done_cr go to LOAD; otherwise stay.
REQ-019 LOAD: host_rdy = 1; each accepted byte drives ioram_en = ioram_we = 1, ioram_addr = wcnt, ioram_din = host_data in the same cycle; wcnt increments.
REQ-020 host_rdy SHALL be 0 in every state except LOAD.
REQ-021 LOAD, accepted byte with host_last = 1 and wcnt >= 1: char_cnt <= wcnt; clear wcnt; go to RUN_GO.
REQ-022 LOAD, host_last on the first byte (wcnt = 0): write the byte; set err_short; clear wcnt; stay in LOAD. The job is discarded and no engine pulse is issued.
REQ-023 LOAD, byte accepted at wcnt = 4095 without host_last: treat it as last; set err_ovf; char_cnt = 4095; go to RUN_GO.
REQ-024 RUN_GO: assert init_lzw for exactly 1 cycle; clear the watchdog; go to RUN_WT.
REQ-025 RUN_WT: on lzw_done, sample outram_cnt into ulen and clear rcnt.
  - ulen = 0: go to CR_GO.
  - ulen != 0: go to UL_RD.
REQ-026 Watchdog (16-bit) counts every cycle in CR_WT and RUN_WT. When it reaches 0xFFFF with no done pulse: set err_tmo, go to CR_GO.
REQ-027 UL_RD: drive outram_en = 1, outram_addr = rcnt; go to UL_OUT.
REQ-028 UL_OUT, first cycle: capture outram_dout into a holding register. Then out_vld = 1, out_data = the held byte, out_last = (rcnt = ulen-1).
REQ-029 out_vld and out_data SHALL stay stable until out_rdy.
REQ-030 UL_OUT, on out_vld & out_rdy: rcnt increments.
  - If out_last: go to CR_GO, so the code RAM is re-initialised for every job.
  - Otherwise: go to UL_RD.
REQ-031 Throughput: one unload byte per 2 cycles at best.
REQ-032 Width rules: wcnt, rcnt and ulen are 12-bit unsigned.
REQ-033 outram_cnt and done pulses arriving outside their wait state SHALL be ignored.
REQ-034 init_cr and init_lzw SHALL never be asserted in the same cycle.

Reset
REQ-035 Reset SHALL take effect on any cycle, including mid-load and mid-unload; it aborts the job and discards all counters.
REQ-036 Reset values: state = CR_GO; wcnt = rcnt = ulen = char_cnt = 0; watchdog = 0; all error flags = 0.
REQ-037 Reset values of the outputs: init_cr = init_lzw = 0, host_rdy = 0, out_vld = 0, all RAM enables = 0.
REQ-038 The first cycle after reset release SHALL issue init_cr.

Verification
REQ-039 Reset release -> init_cr high exactly 1 cycle; done_cr after 2048 cycles -> host_rdy = 1.
REQ-040 Load 5 bytes, last on the 5th -> ioram writes at addresses 0..4; char_cnt = 4; init_lzw 1 cycle later.
REQ-041 lzw_done with outram_cnt = 3, out_rdy toggling 50% -> 3 bytes from addresses 0,1,2 in order, out_last on the 3rd; then init_cr.
REQ-042 host_last on the first byte -> err_short = 1; no init_lzw; host_rdy stays 1.
REQ-043 Load 4096 bytes without last -> err_ovf = 1; char_cnt = 4095. Withhold lzw_done -> err_tmo = 1 after 65535 cycles; next state CR_GO.
REQ-044 rst_n low during UL_OUT -> out_vld = 0 next cycle; the sequence restarts from CR_GO.
